mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the RV32IC pipeline, directly downstream of alu. Takes o_ALUOutput as
//  effective address (or plain result), rs2 as store data, func3 as access width.
//  Runs a req/gnt/rvalid handshake to data memory; aligns, masks and extends data.
//  Produces the write-back record and stalls upstream while an access is in flight.
// PARAMETERS
//  TIMEOUT   64   cycles in WAIT without i_mem_rvalid before o_bus_err pulses
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset        in   1   synchronous, active-low reset
//  i_valid        in   1   EX result valid this cycle
//  i_ALUOutput    in   32  effective address / ALU result
//  i_B            in   32  rs2 (store data)
//  i_func3        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_is_load      in   1   load op
//  i_is_store     in   1   store op (is_load & is_store never both 1)
//  i_rd           in   5   destination register
//  o_ready        out  1   stage accepts i_valid this cycle
//  o_mem_req      out  1   data-memory request
//  o_mem_we       out  1   1 = write
//  o_mem_addr     out  32  word address, bits[1:0] = 00
//  o_mem_wdata    out  32  lane-replicated store data
//  o_mem_be       out  4   byte enables
//  i_mem_gnt      in   1   request accepted
//  i_mem_rvalid   in   1   response valid (loads and stores)
//  i_mem_rdata    in   32  load data
//  o_wb_valid     out  1   write-back record valid (1-cycle pulse)
//  o_wb_rd        out  5   destination register
//  o_wb_data      out  32  result / extended load data (0 for stores)
//  o_misalign     out  1   1-cycle pulse: misaligned load/store
//  o_bus_err      out  1   1-cycle pulse: response timeout
// BEHAVIOUR
//  Reset (i_reset==0 at edge): state IDLE, timeout counter 0, every output 0 except o_ready=1.
//  FSM IDLE -> REQ -> WAIT -> IDLE. o_ready = (state==IDLE).
//  IDLE, i_valid, not mem op: latch; o_wb_valid=1 next cycle, o_wb_data=i_ALUOutput. Latency 1.
//  IDLE, i_valid, mem op, aligned: latch addr/data/func3/rd -> REQ. Aligned: H needs a[0]=0,
//   W needs a[1:0]=00, func3 011/110/111 treated as W.
//  Misaligned: no request; next cycle o_misalign=1, o_wb_valid=0; stay IDLE.
//  REQ: o_mem_req=1; addr/we/wdata/be held stable until i_mem_gnt sampled 1 -> WAIT.
//  WAIT: o_mem_req=0; counter++. i_mem_rvalid -> o_wb_valid=1 next cycle -> IDLE
//   (stores: o_wb_valid=1 with o_wb_data=0; rd passed through, WB ignores it).
//  Counter reaching TIMEOUT with no rvalid: o_bus_err pulse, o_wb_valid=0 -> IDLE.
//  gnt and rvalid same cycle in REQ: both honoured, skip WAIT (REQ -> IDLE).
//  rvalid outside WAIT/REQ-with-gnt: ignored.
//  Store: B be=0001<<a[1:0], wdata={4{b}}; H be=0011<<a[1:0], wdata={2{h}}; W be=1111.
//  Load: byte/half selected by a[1:0]; B/H sign-extend, BU/HU zero-extend.
//  Reset mid-REQ/WAIT: access abandoned, no wb/err pulse; late rvalid ignored.
// STRUCTURE
//  Shared package rv32_pkg: func3 width constants (F3_B..F3_HU), mem_state_t enum
//   {IDLE,REQ,WAIT}, wb record struct. One sub-module: mem_align (combinational store
//   lane/be generation and load extract/extend), reused by the future LSU.
// TESTING
//  Non-mem 0xDEADBEEF, rd=5 -> next cycle o_wb_valid=1, o_wb_data=0xDEADBEEF, rd=5, no req.
//  LB @0x1003, rdata=0x80112233 -> o_mem_addr=0x1000, be=1000, o_wb_data=0xFFFFFF80;
//   LBU same -> 0x00000080.
//  SH @0x1002, B=0x00001234 -> we=1, be=1100, wdata=0x12341234; wb_data=0.
//  LW @0x1001 -> o_misalign pulse, o_mem_req stays 0, o_ready=1 throughout.
//  gnt delayed 3 cycles -> req/addr/be stable 4 cycles, o_ready=0 until wb pulse.
//  Reset low during WAIT, rvalid 2 cycles later -> outputs 0, o_ready=1, no o_wb_valid;
//   no rvalid for 64 cycles (no reset) -> o_bus_err pulse, back to IDLE.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types: load/store width codes, MEM-stage FSM states
// and the write-back record handed to the register file.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_rec_t;

  // Unknown width codes (011/110/111) behave like full-word accesses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = a[0];
      default:     mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data memory: store lane replication and byte enables,
// load byte/half extraction with sign or zero extension.
module mem_align
  import rv32_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = rdata_i >> {offset_i, 3'b000};
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = shifted;
    case (func3_i)
      F3_B, F3_BU: begin
        be_o        = 4'b0001 << offset_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = (func3_i == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'b0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be_o        = 4'b0011 << offset_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = (func3_i == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'b0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: forwards ALU results, runs the req/gnt/rvalid data-memory handshake,
// and produces one write-back record (or a misalign / timeout pulse) per op.
module mem_access_stage
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_B,
  input  logic [2:0]  i_func3,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [4:0]  i_rd,
  output logic        o_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [2:0]        func3_q, func3_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_q, we_d;
  wb_rec_t           wb_q, wb_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;

  mem_align u_align (
    .func3_i      (func3_q),
    .offset_i     (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (i_mem_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (load_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      func3_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wb_q       <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      func3_q    <= func3_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    func3_d    = func3_q;
    rd_d       = rd_q;
    we_d       = we_q;
    wb_d       = '0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!i_is_load && !i_is_store) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = i_rd;
            wb_d.data  = i_ALUOutput;
          end else if (is_misaligned(i_func3, i_ALUOutput[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = i_ALUOutput;
            sdata_d = i_B;
            func3_d = i_func3;
            rd_d    = i_rd;
            we_d    = i_is_store;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A response arriving together with the grant completes the access at once.
        if (i_mem_gnt) begin
          cnt_d = '0;
          if (i_mem_rvalid) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = rd_q;
            wb_d.data  = we_q ? 32'h0 : load_data;
            state_d    = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          wb_d.valid = 1'b1;
          wb_d.rd    = rd_q;
          wb_d.data  = we_q ? 32'h0 : load_data;
          state_d    = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready     = (state_q == IDLE);
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_addr  = o_mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign o_mem_wdata = (o_mem_req && we_q) ? lane_wdata : 32'h0;
  assign o_mem_be    = o_mem_req ? lane_be : 4'b0000;
  assign o_wb_valid  = wb_q.valid;
  assign o_wb_rd     = wb_q.rd;
  assign o_wb_data   = wb_q.data;
  assign o_misalign  = misalign_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// operations compared against an arithmetic model of the MEM-stage rules.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_ALUOutput;
  logic [31:0] i_B;
  logic [2:0]  i_func3;
  logic        i_is_load;
  logic        i_is_store;
  logic [4:0]  i_rd;
  logic        o_ready;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_misalign;
  logic        o_bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(64)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_ALUOutput  (i_ALUOutput),
    .i_B          (i_B),
    .i_func3      (i_func3),
    .i_is_load    (i_is_load),
    .i_is_store   (i_is_store),
    .i_rd         (i_rd),
    .o_ready      (o_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_misalign   (o_misalign),
    .o_bus_err    (o_bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Access size in bytes; unknown width codes count as words.
  function automatic int accSize(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int     size = accSize(f3);
    int     off  = int'(addr % 4);
    longint v;
    v = (longint'({32'b0, rdata}) >> (8 * off)) % (longint'(1) << (8 * size));
    if (size < 4 && (f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  function automatic logic [31:0] refBe(input logic [2:0] f3, input logic [31:0] addr);
    int x = ((1 << accSize(f3)) - 1) << int'(addr % 4);
    return {28'b0, x[3:0]};
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] b);
    case (accSize(f3))
      1:       return (b & 32'h000000FF) * 32'h01010101;
      2:       return (b & 32'h0000FFFF) * 32'h00010001;
      default: return b;
    endcase
  endfunction

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] b, input logic [4:0] rd);
    i_valid     = 1'b1;
    i_is_load   = ld;
    i_is_store  = st;
    i_func3     = f3;
    i_ALUOutput = addr;
    i_B         = b;
    i_rd        = rd;
    tick();
    i_valid    = 1'b0;
    i_is_load  = 1'b0;
    i_is_store = 1'b0;
  endtask

  // One complete operation from issue to the cycle after its result pulse.
  task automatic runOp(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] b, input logic [31:0] rdata,
                       input logic [4:0] rd, input int gntDelay, input int waitCycles, input bit sameCycle);
    applyStimulus(ld, st, f3, addr, b, rd);
    if (!ld && !st) begin
      checkOutput({tag, ".wb_valid"}, o_wb_valid, 1);
      checkOutput({tag, ".wb_data"}, o_wb_data, addr);
      checkOutput({tag, ".wb_rd"}, o_wb_rd, rd);
      checkOutput({tag, ".req"}, o_mem_req, 0);
      checkOutput({tag, ".ready"}, o_ready, 1);
    end else if ((addr % accSize(f3)) != 0) begin
      checkOutput({tag, ".misalign"}, o_misalign, 1);
      checkOutput({tag, ".wb_valid"}, o_wb_valid, 0);
      checkOutput({tag, ".req"}, o_mem_req, 0);
      checkOutput({tag, ".ready"}, o_ready, 1);
    end else begin
      for (int d = 0; d <= gntDelay; d++) begin
        checkOutput({tag, ".req"}, o_mem_req, 1);
        checkOutput({tag, ".ready"}, o_ready, 0);
        checkOutput({tag, ".addr"}, o_mem_addr, addr - (addr % 4));
        checkOutput({tag, ".be"}, {28'b0, o_mem_be}, refBe(f3, addr));
        checkOutput({tag, ".we"}, o_mem_we, st);
        if (st) checkOutput({tag, ".wdata"}, o_mem_wdata, refWdata(f3, b));
        i_mem_gnt    = (d == gntDelay);
        i_mem_rvalid = (d == gntDelay) ? sameCycle : 1'($urandom_range(0, 1));
        i_mem_rdata  = (d == gntDelay) ? rdata : $urandom;
        tick();
      end
      i_mem_gnt = 1'b0;
      if (!sameCycle) begin
        i_mem_rvalid = 1'b0;
        for (int w = 0; w <= waitCycles; w++) begin
          checkOutput({tag, ".wait_req"}, o_mem_req, 0);
          checkOutput({tag, ".wait_ready"}, o_ready, 0);
          checkOutput({tag, ".wait_wb"}, o_wb_valid, 0);
          if (w == waitCycles) i_mem_rvalid = 1'b1;
          tick();
        end
      end
      i_mem_rvalid = 1'b0;
      checkOutput({tag, ".wb_valid"}, o_wb_valid, 1);
      checkOutput({tag, ".wb_rd"}, o_wb_rd, rd);
      checkOutput({tag, ".wb_data"}, o_wb_data, st ? 32'h0 : refLoad(f3, addr, rdata));
      checkOutput({tag, ".ready_done"}, o_ready, 1);
      checkOutput({tag, ".bus_err"}, o_bus_err, 0);
    end
    tick();
    checkOutput({tag, ".wb_pulse_end"}, o_wb_valid, 0);
    checkOutput({tag, ".misalign_end"}, o_misalign, 0);
  endtask

  initial begin
    i_reset      = 1'b0;
    i_valid      = 1'b0;
    i_ALUOutput  = '0;
    i_B          = '0;
    i_func3      = '0;
    i_is_load    = 1'b0;
    i_is_store   = 1'b0;
    i_rd         = '0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst.ready", o_ready, 1);
    checkOutput("rst.req", o_mem_req, 0);
    checkOutput("rst.we", o_mem_we, 0);
    checkOutput("rst.addr", o_mem_addr, 0);
    checkOutput("rst.be", {28'b0, o_mem_be}, 0);
    checkOutput("rst.wb_valid", o_wb_valid, 0);
    checkOutput("rst.wb_data", o_wb_data, 0);
    checkOutput("rst.misalign", o_misalign, 0);
    checkOutput("rst.bus_err", o_bus_err, 0);
    i_reset = 1'b1;
    tick();

    $display("[TB] directed operations");
    runOp("alu", 0, 0, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 0, 0, 0);
    runOp("lb", 1, 0, 3'b000, 32'h00001003, 32'h0, 32'h80112233, 5'd1, 0, 0, 0);
    runOp("lbu", 1, 0, 3'b100, 32'h00001003, 32'h0, 32'h80112233, 5'd2, 0, 0, 0);
    runOp("sh", 0, 1, 3'b001, 32'h00001002, 32'h00001234, 32'h0, 5'd3, 0, 1, 0);
    runOp("lw_mis", 1, 0, 3'b010, 32'h00001001, 32'h0, 32'h0, 5'd4, 0, 0, 0);
    runOp("lw_gnt3", 1, 0, 3'b010, 32'h00002004, 32'h0, 32'hCAFEF00D, 5'd6, 3, 2, 0);
    runOp("lh_same", 1, 0, 3'b001, 32'h00002006, 32'h0, 32'h9ABC1234, 5'd7, 1, 0, 1);
    runOp("sb", 0, 1, 3'b000, 32'h00003001, 32'h000000A5, 32'h0, 5'd8, 0, 0, 0);

    // Hard-coded expectations for the headline load cases, independent of the model.
    applyStimulus(1, 0, 3'b000, 32'h00001003, 32'h0, 5'd9);
    checkOutput("lb_hc.addr", o_mem_addr, 32'h00001000);
    checkOutput("lb_hc.be", {28'b0, o_mem_be}, 32'h8);
    i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80112233;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    checkOutput("lb_hc.wb_data", o_wb_data, 32'hFFFFFF80);
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(1, 0, 3'b010, 32'h00004000, 32'h0, 5'd10);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    checkOutput("rstw.in_wait", o_ready, 0);
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    checkOutput("rstw.ready", o_ready, 1);
    checkOutput("rstw.req", o_mem_req, 0);
    checkOutput("rstw.wb_valid", o_wb_valid, 0);
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
    tick();
    i_mem_rvalid = 1'b0;
    checkOutput("rstw.late_wb", o_wb_valid, 0);
    checkOutput("rstw.late_ready", o_ready, 1);
    checkOutput("rstw.late_err", o_bus_err, 0);

    $display("[TB] response timeout");
    applyStimulus(1, 0, 3'b010, 32'h00005000, 32'h0, 5'd11);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    checkOutput("tmo.no_err_yet", o_bus_err, 0);
    checkOutput("tmo.still_busy", o_ready, 0);
    tick();
    checkOutput("tmo.bus_err", o_bus_err, 1);
    checkOutput("tmo.ready", o_ready, 1);
    checkOutput("tmo.wb_valid", o_wb_valid, 0);
    tick();
    checkOutput("tmo.err_pulse_end", o_bus_err, 0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] addr;
      kind = int'($urandom_range(0, 2));
      addr = $urandom;
      runOp($sformatf("rnd%0d", n), kind == 1, kind == 2, 3'($urandom_range(0, 7)), addr,
            $urandom, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
